// File: rtl/alu_seq_pkg.sv
// Shared opcodes, flag bit positions and FSM states for the sequential ALU.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    CMD_ADD = 4'h0,
    CMD_SUB = 4'h1,
    CMD_SHR = 4'h2,
    CMD_SHL = 4'h3,
    CMD_XOR = 4'h4,
    CMD_AND = 4'h5,
    CMD_OR  = 4'h6,
    CMD_MOV = 4'h7,
    CMD_MUL = 4'h8,
    CMD_DIV = 4'h9
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_ITER,
    S_FIX,
    S_DONE
  } state_e;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_DIV0  = 3;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider.
module alu_muldiv_iter #(
  parameter int DATA_W   = 32,
  parameter int MD_RADIX = 1,
  parameter int CNT_W    = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              div_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [DATA_W-1:0] hi_o
);

  localparam int STEPS = DATA_W / MD_RADIX;

  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              div_q, div_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W:0]   t;

  // hi holds product-high / remainder, lo holds multiplier / quotient
  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    b_d   = b_q;
    div_d = div_q;
    cnt_d = cnt_q;
    t     = '0;
    if (load_i) begin
      hi_d  = '0;
      lo_d  = a_i;
      b_d   = b_i;
      div_d = div_i;
      cnt_d = CNT_W'(STEPS);
    end else if (cnt_q != '0) begin
      for (int k = 0; k < MD_RADIX; k++) begin
        if (div_q) begin
          t = {hi_d, lo_d[DATA_W-1]};
          if (t >= {1'b0, b_q}) begin
            t    = t - {1'b0, b_q};
            lo_d = {lo_d[DATA_W-2:0], 1'b1};
          end else begin
            lo_d = {lo_d[DATA_W-2:0], 1'b0};
          end
          hi_d = t[DATA_W-1:0];
        end else begin
          t = lo_d[0] ? {1'b0, hi_d} + {1'b0, b_q}
                      : {1'b0, hi_d};
          lo_d = {t[0], lo_d[DATA_W-1:1]};
          hi_d = t[DATA_W:1];
        end
      end
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  assign ready_o = (cnt_q == '0);
  assign lo_o    = lo_q;
  assign hi_o    = hi_q;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: start/busy/done handshake, single-cycle datapath,
// signed MUL/DIV around an iterative unsigned engine, status flags.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MD_RADIX = 1,
  parameter int CNT_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [3:0]        cmd_code,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] src0,
  input  logic [DATA_W-1:0] src1,
  output logic [DATA_W-1:0] dst,
  output logic [DATA_W-1:0] dst_h,
  output logic [3:0]        flags,
  output logic              busy,
  output logic              done
);

  localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, b_q, dst_q, dsth_q;
  logic [3:0]        cmd_q, flags_q;
  logic              sgn_q;

  logic              latch, ld, upd;
  logic              in_md, in_div0;
  logic [DATA_W-1:0] mag0, mag1;
  logic              eng_rdy;
  logic [DATA_W-1:0] eng_lo, eng_hi;

  logic [DATA_W:0]     sum, diff;
  logic [2*DATA_W-1:0] prod, sprod;
  logic                qneg, rneg;
  logic [DATA_W-1:0]   r_dst, r_hi;
  logic [3:0]          r_flags;

  assign in_md   = (cmd_code == CMD_MUL) || (cmd_code == CMD_DIV);
  assign in_div0 = (cmd_code == CMD_DIV) && (src1 == '0);
  assign mag0    = (is_signed && src0[DATA_W-1]) ? -src0 : src0;
  assign mag1    = (is_signed && src1[DATA_W-1]) ? -src1 : src1;

  alu_muldiv_iter #(
    .DATA_W  (DATA_W),
    .MD_RADIX(MD_RADIX),
    .CNT_W   (CNT_W)
  ) u_iter (
    .clk    (clk),
    .rst_n  (rst),
    .load_i (ld),
    .div_i  (cmd_code == CMD_DIV),
    .a_i    (mag0),
    .b_i    (mag1),
    .ready_o(eng_rdy),
    .lo_o   (eng_lo),
    .hi_o   (eng_hi)
  );

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    ld      = 1'b0;
    upd     = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        latch = 1'b1;
        if (in_md && !in_div0) begin
          ld      = 1'b1;
          state_d = S_ITER;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        upd     = 1'b1;
        state_d = S_DONE;
      end
      S_ITER: if (abort) begin
        state_d = S_IDLE;
      end else if (eng_rdy) begin
        if (sgn_q) begin
          state_d = S_FIX;
        end else begin
          upd     = 1'b1;
          state_d = S_DONE;
        end
      end
      S_FIX: if (abort) begin
        state_d = S_IDLE;
      end else begin
        upd     = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign qneg = sgn_q & (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
  assign rneg = sgn_q & a_q[DATA_W-1];

  always_comb begin
    r_dst   = '0;
    r_hi    = '0;
    r_flags = '0;
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = {1'b0, a_q} - {1'b0, b_q};
    prod    = {eng_hi, eng_lo};
    sprod   = qneg ? -prod : prod;
    unique case (cmd_q)
      CMD_ADD: begin
        r_dst = sum[DATA_W-1:0];
        r_hi  = {{(DATA_W-1){1'b0}}, sum[DATA_W]};
        r_flags[FLAG_CARRY] = sum[DATA_W];
        r_flags[FLAG_OVF]   = (a_q[DATA_W-1] == b_q[DATA_W-1])
                           && (sum[DATA_W-1] != a_q[DATA_W-1]);
      end
      CMD_SUB: begin
        r_dst = diff[DATA_W-1:0];
        r_hi  = {DATA_W{diff[DATA_W]}};
        r_flags[FLAG_CARRY] = diff[DATA_W];
        r_flags[FLAG_OVF]   = (a_q[DATA_W-1] != b_q[DATA_W-1])
                           && (diff[DATA_W-1] != a_q[DATA_W-1]);
      end
      CMD_SHR: r_dst = (b_q >= DATA_W'(DATA_W)) ? '0 : a_q >> b_q;
      CMD_SHL: r_dst = (b_q >= DATA_W'(DATA_W)) ? '0 : a_q << b_q;
      CMD_XOR: r_dst = a_q ^ b_q;
      CMD_AND: r_dst = a_q & b_q;
      CMD_OR:  r_dst = a_q | b_q;
      CMD_MUL: begin
        {r_hi, r_dst} = sprod;
        r_flags[FLAG_OVF] = sgn_q
          ? (sprod[2*DATA_W-1:DATA_W] != {DATA_W{sprod[DATA_W-1]}})
          : (prod[2*DATA_W-1:DATA_W] != '0);
      end
      CMD_DIV: if (b_q == '0) begin
        r_dst = '1;
        r_hi  = a_q;
        r_flags[FLAG_DIV0] = 1'b1;
      end else begin
        r_dst = qneg ? -eng_lo : eng_lo;
        r_hi  = rneg ? -eng_hi : eng_hi;
        r_flags[FLAG_OVF] = sgn_q && (a_q == MIN_V) && (b_q == '1);
      end
      default: r_dst = a_q;
    endcase
    r_flags[FLAG_ZERO] = (r_dst == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cmd_q   <= '0;
      sgn_q   <= 1'b0;
      dst_q   <= '0;
      dsth_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        a_q   <= src0;
        b_q   <= src1;
        cmd_q <= cmd_code;
        sgn_q <= is_signed;
      end
      if (upd) begin
        dst_q   <= r_dst;
        dsth_q  <= r_hi;
        flags_q <= r_flags;
      end
    end
  end

  assign dst   = dst_q;
  assign dst_h = dsth_q;
  assign flags = flags_q;
  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_alu_seq.sv
// Randomised self-checking bench for alu_seq against an arithmetic model.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         is_signed = 1'b0;
  logic [3:0]   cmd_code = 4'h0;
  logic [W-1:0] src0 = '0;
  logic [W-1:0] src1 = '0;
  logic [W-1:0] dst, dst_h;
  logic [3:0]   flags;
  logic         busy, done;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_seq #(.DATA_W(W), .MD_RADIX(1), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .cmd_code (cmd_code),
    .is_signed(is_signed),
    .src0     (src0),
    .src1     (src1),
    .dst      (dst),
    .dst_h    (dst_h),
    .flags    (flags),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic ref_model(input logic [3:0] c, input logic s,
                           input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] ed, output logic [31:0] eh,
                           output logic [3:0] ef, output int lat);
    logic [63:0] u;
    longint      sl;
    int          sa, sb;
    logic        dz, ov, cy;
    ed = a; eh = '0; dz = 0; ov = 0; cy = 0; lat = 1;
    sa = int'(a);
    sb = int'(b);
    case (c)
      CMD_ADD: begin
        u  = {32'd0, a} + {32'd0, b};
        ed = u[31:0]; eh = u[63:32]; cy = u[32];
        sl = longint'(sa) + longint'(sb);
        ov = (sl != longint'(int'(ed)));
      end
      CMD_SUB: begin
        u  = {32'd0, a} - {32'd0, b};
        ed = u[31:0]; eh = u[63:32]; cy = (a < b);
        sl = longint'(sa) - longint'(sb);
        ov = (sl != longint'(int'(ed)));
      end
      CMD_SHR: ed = (b >= 32) ? '0 : a >> b;
      CMD_SHL: ed = (b >= 32) ? '0 : a << b;
      CMD_XOR: ed = a ^ b;
      CMD_AND: ed = a & b;
      CMD_OR:  ed = a | b;
      CMD_MUL: begin
        lat = s ? 34 : 33;
        if (s) begin
          sl = longint'(sa) * longint'(sb);
          u  = sl;
          ov = (sl != longint'(int'(u[31:0])));
        end else begin
          u  = {32'd0, a} * {32'd0, b};
          ov = (u[63:32] != 0);
        end
        ed = u[31:0]; eh = u[63:32];
      end
      CMD_DIV: begin
        if (b == 0) begin
          ed = '1; eh = a; dz = 1;
        end else begin
          lat = s ? 34 : 33;
          if (!s) begin
            ed = a / b; eh = a % b;
          end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            ed = a; eh = '0; ov = 1;
          end else begin
            ed = sa / sb; eh = sa % sb;
          end
        end
      end
      default: ;
    endcase
    ef = {dz, ov, cy, ed == 0};
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 100) begin
      @(posedge clk); #1; g++;
    end
    chk("idle_wait", 64'(busy), 64'd0);
  endtask

  task automatic run_op(input logic [3:0] c, input logic s,
                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ed, eh;
    logic [3:0]  ef;
    int          lat, cyc;
    string       t;
    ref_model(c, s, a, b, ed, eh, ef, lat);
    t = $sformatf("c%0h_s%0d_%h_%h", c, s, a, b);
    wait_idle();
    @(negedge clk);
    cmd_code = c; is_signed = s; src0 = a; src1 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    src0 = $urandom; src1 = $urandom;
    cmd_code = 4'($urandom); is_signed = 1'($urandom);
    cyc = 0;
    while (!done && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    chk({t, " lat"}, 64'(cyc), 64'(lat));
    chk({t, " dst"}, 64'(dst), 64'(ed));
    chk({t, " dst_h"}, 64'(dst_h), 64'(eh));
    chk({t, " flags"}, 64'(flags), 64'(ef));
    @(posedge clk); #1;
    chk({t, " pulse"}, 64'({done, busy}), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nd;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dst", 64'(dst), 64'd0);
    chk("rst_dst_h", 64'(dst_h), 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_busy_done", 64'({busy, done}), 64'd0);
    @(negedge clk) rst = 1'b1;

    run_op(CMD_ADD, 0, 32'hFFFF_FFFF, 32'h1);
    chk("add_const", {dst_h, dst}, {32'h1, 32'h0});
    run_op(CMD_MUL, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("mul_const", {dst_h, dst}, {32'hFFFF_FFFE, 32'h1});
    run_op(CMD_DIV, 1, 32'hFFFF_FFF9, 32'h2);
    chk("sdiv_const", {dst_h, dst}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(CMD_DIV, 0, 32'd100, 32'd7);
    chk("udiv_const", {dst_h, dst}, {32'd2, 32'd14});
    run_op(CMD_DIV, 0, 32'h1234, 32'h0);
    chk("div0_flag", 64'(flags[FLAG_DIV0]), 64'd1);
    run_op(CMD_DIV, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(CMD_MUL, 1, 32'hFFFF_FFFD, 32'h7);
    run_op(CMD_SUB, 0, 32'h0, 32'h1);
    run_op(CMD_SHR, 0, 32'hF000_0000, 32'd32);
    run_op(CMD_SHL, 0, 32'h1, 32'd31);
    run_op(4'hE, 0, 32'hCAFE_F00D, 32'h5);

    abort = 1'b1;
    run_op(CMD_OR, 0, 32'h00F0, 32'h0F00);
    abort = 1'b0;

    wait_idle();
    @(negedge clk);
    cmd_code = CMD_MUL; is_signed = 0;
    src0 = 32'h1234; src1 = 32'h10; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    nd = 0;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
      start = (i == 5) || done;
      cmd_code = CMD_ADD; src0 = 32'h1; src1 = 32'h1;
    end
    start = 1'b0;
    chk("busy_ign_ndone", 64'(nd), 64'd1);
    chk("busy_ign_dst", {dst_h, dst}, 64'h12340);
    chk("busy_ign_idle", 64'(busy), 64'd0);

    run_op(CMD_ADD, 0, 32'd2, 32'd3);
    @(negedge clk);
    cmd_code = CMD_MUL; is_signed = 1;
    src0 = 32'hFFFF_0001; src1 = 32'h0003_0000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_idle", 64'(busy), 64'd0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("abort_ndone", 64'(nd), 64'd0);
    chk("abort_hold", {dst_h, dst}, 64'd5);

    @(negedge clk);
    cmd_code = CMD_MUL; is_signed = 0;
    src0 = 32'h77; src1 = 32'h99; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mrst_out", {dst_h, dst}, 64'd0);
    chk("mrst_flags", 64'(flags), 64'd0);
    chk("mrst_busy_done", 64'({busy, done}), 64'd0);
    @(negedge clk) rst = 1'b1;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("mrst_ndone", 64'(nd), 64'd0);

    for (int i = 0; i < 60; i++) begin
      run_op(4'($urandom_range(0, 15)), 1'($urandom), pick(), pick());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
